i2c_host_cmd_ctrl: RTL and testbench
====================================

// Module: i2c_host_cmd_ctrl
// PURPOSE
// - Command front-end for I2C_interfaces. Sits between the JTAG instruction decoder and I2C_interfaces.
// - Turns single-beat host commands into I2C_interfaces strobes: WE, START, RESET and RDENA.
// - Returns one response per command: readback byte, status byte or error flag.
// - Owns START hold/clear handshake, RESET pulse stretching and START timeout supervision.
// PARAMETERS
// - Simulation    0    1 = shorten START timeout to SIM_TIMEOUT
// - RST_LEN       11   I2C_RESET high time, CLK40 cycles (1..255)
// - RD_LAT        2    cycles from I2C_RDENA pulse to valid I2C_RBK_FIFO_DATA (1..7)
// - HW_TIMEOUT    24'd4000000  START timeout, CLK40 cycles (100 ms)
// - SIM_TIMEOUT   24'd20000    START timeout when Simulation=1
// PORTS
// - CLK40              in   1  40 MHz system clock, sole clock
// - RST                in   1  synchronous, active-high reset
// - CMD_VALID          in   1  command present
// - CMD_READY          out  1  command accepted when VALID&READY
// - CMD_CODE           in   3  1=WRITE 2=START 3=RESET 4=READ 5=STATUS; others illegal
// - CMD_DATA           in   8  write byte (WRITE only)
// - RSP_VALID          out  1  one-cycle response strobe
// - RSP_DATA           out  8  read byte / status byte, else 0
// - RSP_ERR            out  1  command rejected, or sticky timeout reported by STATUS
// - I2C_WRT_FIFO_DATA  out  8  to I2C_interfaces
// - I2C_WE             out  1  one-cycle write strobe
// - I2C_RDENA          out  1  one-cycle readback-FIFO read strobe
// - I2C_RESET          out  1  held RST_LEN cycles
// - I2C_START          out  1  level, held until I2C_CLR_START or timeout
// - I2C_CLR_START      in   1  from I2C_interfaces: sequence finished
// - I2C_RBK_FIFO_DATA  in   8  from I2C_interfaces
// - I2C_STATUS         in   8  from I2C_interfaces
// BEHAVIOUR
// - Reset: all outputs 0; FSM to IDLE; start_pend, tmo_sticky and counters cleared.
// - CMD_READY is 1 only in IDLE while RST=0. Commands are never queued.
// - FSM states: IDLE, WR, RHOLD, RDW, RSP.
// - IDLE: on accept, latch the code and dispatch by command.
// - WRITE (start_pend=0): go to WR.
//   - Next cycle: I2C_WE=1 for exactly 1 cycle and I2C_WRT_FIFO_DATA=CMD_DATA.
//   - I2C_WRT_FIFO_DATA stays valid on that cycle and the one after.
//   - Then RSP with ERR=0.
// - START (start_pend=0): I2C_START=1 the cycle after accept; start_pend=1; RSP with ERR=0.
//   - The FSM does not wait; I2C_START stays high independently.
// - WRITE, START or READ with start_pend=1: no strobe; RSP with ERR=1 the cycle after accept.
// - RESET (accepted even with start_pend=1): go to RHOLD.
//   - I2C_RESET=1 for RST_LEN cycles starting the cycle after accept.
//   - I2C_START is forced 0; start_pend=0; timeout counter is cleared.
//   - RSP after I2C_RESET falls.
// - READ: I2C_RDENA=1 for one cycle, then RDW for RD_LAT cycles.
//   - Sample I2C_RBK_FIFO_DATA into RSP_DATA; RSP with ERR=0.
// - STATUS: RSP the next cycle with RSP_DATA=I2C_STATUS and RSP_ERR=tmo_sticky.
//   - tmo_sticky clears on the same cycle.
// - Illegal code (0, 6, 7): RSP with ERR=1; no strobes.
// - RSP state: RSP_VALID=1 for 1 cycle, then IDLE. RSP_DATA holds until the next RSP.
// - START supervision:
//   - While start_pend=1 the 24-bit counter increments every cycle.
//   - I2C_CLR_START=1: I2C_START=0, start_pend=0, counter cleared.
//   - Counter reaches the timeout value: same clear, and tmo_sticky=1.
//   - CLR_START on the same cycle as reaching the timeout counts as a clear; tmo_sticky stays 0.
//   - CLR_START with start_pend=0 is ignored.
// - RST asserted mid-operation: immediate return to reset state. No RSP is issued for the aborted command.
// - Latency, accept to RSP_VALID: WRITE 3, START 2, READ 3+RD_LAT, RESET RST_LEN+2, STATUS 2, error 2.
// STRUCTURE
// - i2c_host_defs.vh:
//   - CMD_* code localparams (3 bits) and FSM state encodings.
//   - Timeout select macro: (Simulation ? SIM_TIMEOUT : HW_TIMEOUT).
// - One sub-module, i2c_start_timer.
//   - Inputs: CLK40, RST, arm, clr, limit[23:0].
//   - Outputs: pend, tmo_pls.
//   - Owns start_pend, the counter and the CLR-versus-timeout priority.
// - Top level: FSM, strobe generation, response register, tmo_sticky.
// TESTING
// - WRITE A1 then WRITE 80 -> two I2C_WE pulses, 1 cycle each, with data A1 and 80; two RSP with ERR=0.
// - START, then CLR_START 500 cycles later -> I2C_START high 500 cycles, then 0.
//   - A WRITE sent meanwhile gets RSP_ERR=1 with no WE; STATUS then shows ERR=0.
// - START with CLR_START never asserted (Simulation=1) -> I2C_START drops after 20000 cycles.
//   - STATUS returns ERR=1; a second STATUS returns ERR=0.
// - RESET during a pending START -> I2C_START=0 the next cycle and I2C_RESET high exactly 11 cycles.
//   - RSP arrives 13 cycles after accept.
// - READ with RBK data 5A, RD_LAT=2 -> one RDENA pulse; RSP_DATA=5A at cycle 5 after accept.
//   - Illegal code 7 -> RSP_ERR=1 and no strobes.
// - RST mid-RHOLD and CLR_START coincident with the timeout cycle -> outputs 0 next cycle; tmo_sticky stays 0.

Source files
------------

// File: rtl/i2c_host_cmd_ctrl_pkg.sv
// Shared command codes, FSM states and timeout selection for the I2C host command front-end.
package i2c_host_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_WRITE  = 3'd1,
    CMD_START  = 3'd2,
    CMD_RESET  = 3'd3,
    CMD_READ   = 3'd4,
    CMD_STATUS = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RHOLD,
    ST_RDW,
    ST_RSP
  } state_e;

  function automatic logic [23:0] timeout_sel(input bit sim, input logic [23:0] sim_t,
                                              input logic [23:0] hw_t);
    return sim ? sim_t : hw_t;
  endfunction

endpackage

// File: rtl/i2c_host_cmd_ctrl_start_timer.sv
// START supervision: owns the pending flag, the timeout counter and CLR-versus-timeout priority.
module i2c_start_timer (
  input  logic        CLK40,
  input  logic        RST,
  input  logic        arm,
  input  logic        clr,
  input  logic [23:0] limit,
  output logic        pend,
  output logic        tmo_pls
);

  logic        pend_q, pend_d;
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] cnt_inc;

  // Arm only from idle; while pending, a clear beats a coincident timeout.
  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tmo_pls = 1'b0;
    cnt_inc = cnt_q + 24'd1;
    if (!pend_q) begin
      if (arm) begin
        pend_d = 1'b1;
        cnt_d  = '0;
      end
    end else if (clr) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (cnt_inc == limit) begin
      pend_d  = 1'b0;
      cnt_d   = '0;
      tmo_pls = 1'b1;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  // State register.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/i2c_host_cmd_ctrl.sv
// Host command front-end: decodes single-beat commands into I2C_interfaces strobes and responses.
module i2c_host_cmd_ctrl
  import i2c_host_cmd_ctrl_pkg::*;
#(
  parameter bit          Simulation  = 1'b0,
  parameter int unsigned RST_LEN     = 11,
  parameter int unsigned RD_LAT      = 2,
  parameter logic [23:0] HW_TIMEOUT  = 24'd4000000,
  parameter logic [23:0] SIM_TIMEOUT = 24'd20000
) (
  input  logic       CLK40,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_CODE,
  input  logic [7:0] CMD_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic [7:0] I2C_WRT_FIFO_DATA,
  output logic       I2C_WE,
  output logic       I2C_RDENA,
  output logic       I2C_RESET,
  output logic       I2C_START,
  input  logic       I2C_CLR_START,
  input  logic [7:0] I2C_RBK_FIFO_DATA,
  input  logic [7:0] I2C_STATUS
);

  localparam logic [23:0] TMO_LIMIT = timeout_sel(Simulation, SIM_TIMEOUT, HW_TIMEOUT);
  localparam logic [7:0]  RST_LAST  = 8'(RST_LEN - 1);
  localparam logic [7:0]  RD_LAST   = 8'(RD_LAT);

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rbk_q, rbk_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       rdena_q, rdena_d;
  logic       rst_out_q, rst_out_d;
  logic       tmo_sticky_q, tmo_sticky_d;
  logic       cmd_ready, accept, arm, clr_by_reset, pend, tmo_pls;

  assign cmd_ready = (state_q == ST_IDLE) && !RST;
  assign accept    = CMD_VALID && cmd_ready;

  i2c_start_timer u_start_timer (
    .CLK40  (CLK40),
    .RST    (RST),
    .arm    (arm),
    .clr    (I2C_CLR_START | clr_by_reset),
    .limit  (TMO_LIMIT),
    .pend   (pend),
    .tmo_pls(tmo_pls)
  );

  // Next-state, strobe and response computation.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    rbk_d        = rbk_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    rdena_d      = 1'b0;
    rst_out_d    = rst_out_q;
    tmo_sticky_d = tmo_sticky_q;
    arm          = 1'b0;
    clr_by_reset = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          code_d  = CMD_CODE;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RSP;
          case (CMD_CODE)
            CMD_WRITE: begin
              if (pend) err_d = 1'b1;
              else begin
                we_d    = 1'b1;
                wdata_d = CMD_DATA;
                state_d = ST_WR;
              end
            end
            CMD_START: begin
              if (pend) err_d = 1'b1;
              else arm = 1'b1;
            end
            CMD_RESET: begin
              rst_out_d    = 1'b1;
              clr_by_reset = 1'b1;
              state_d      = ST_RHOLD;
            end
            CMD_READ: begin
              if (pend) err_d = 1'b1;
              else begin
                rdena_d = 1'b1;
                state_d = ST_RDW;
              end
            end
            CMD_STATUS: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_WR: state_d = ST_RSP;
      ST_RHOLD: begin
        if (cnt_q == RST_LAST) begin
          rst_out_d = 1'b0;
          state_d   = ST_RSP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Count starts on the RDENA cycle, so the sample lands RD_LAT cycles after the pulse.
      ST_RDW: begin
        if (cnt_q == RD_LAST) begin
          rbk_d   = I2C_RBK_FIFO_DATA;
          state_d = ST_RSP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RSP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_data_d  = '0;
        if (code_q == CMD_STATUS) begin
          rsp_data_d   = I2C_STATUS;
          rsp_err_d    = tmo_sticky_q;
          tmo_sticky_d = 1'b0;
        end else if (code_q == CMD_READ && !err_q) begin
          rsp_data_d = rbk_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_pls) tmo_sticky_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      code_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rbk_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdena_q      <= 1'b0;
      rst_out_q    <= 1'b0;
      tmo_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rbk_q        <= rbk_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdena_q      <= rdena_d;
      rst_out_q    <= rst_out_d;
      tmo_sticky_q <= tmo_sticky_d;
    end
  end

  assign CMD_READY         = cmd_ready;
  assign RSP_VALID         = rsp_valid_q;
  assign RSP_DATA          = rsp_data_q;
  assign RSP_ERR           = rsp_err_q;
  assign I2C_WRT_FIFO_DATA = wdata_q;
  assign I2C_WE            = we_q;
  assign I2C_RDENA         = rdena_q;
  assign I2C_RESET         = rst_out_q;
  assign I2C_START         = pend;

endmodule

// File: tb/tb_i2c_host_cmd_ctrl.sv
// Self-checking bench for i2c_host_cmd_ctrl: vector table, directed corner cases, random commands.
module tb_i2c_host_cmd_ctrl;

  localparam int RST_LEN = 11;
  localparam int RD_LAT  = 2;
  localparam int TMO     = 20000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data, wrt_data, rbk_data, status;
  logic       we, rdena, i2c_reset, i2c_start, clr_start;

  always #5 clk = ~clk;

  i2c_host_cmd_ctrl #(
    .Simulation (1'b1),
    .RST_LEN    (RST_LEN),
    .RD_LAT     (RD_LAT),
    .HW_TIMEOUT (24'd4000000),
    .SIM_TIMEOUT(24'd20000)
  ) dut (
    .CLK40            (clk),
    .RST              (rst),
    .CMD_VALID        (cmd_valid),
    .CMD_READY        (cmd_ready),
    .CMD_CODE         (cmd_code),
    .CMD_DATA         (cmd_data),
    .RSP_VALID        (rsp_valid),
    .RSP_DATA         (rsp_data),
    .RSP_ERR          (rsp_err),
    .I2C_WRT_FIFO_DATA(wrt_data),
    .I2C_WE           (we),
    .I2C_RDENA        (rdena),
    .I2C_RESET        (i2c_reset),
    .I2C_START        (i2c_start),
    .I2C_CLR_START    (clr_start),
    .I2C_RBK_FIFO_DATA(rbk_data),
    .I2C_STATUS       (status)
  );

  typedef struct {
    int         lat;
    int         we_n;
    logic [7:0] wd;
    int         rd_n;
    int         rst_n;
    logic       err;
    logic [7:0] data;
    logic       start1;
  } res_t;

  typedef struct {
    logic [2:0] code;
    logic [7:0] data;
    logic [7:0] rbk;
    logic [7:0] stat;
    res_t       exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int start_run = 0, last_start_len = 0;
  bit m_pend, m_sticky;

  // Length of the most recent complete high run of I2C_START.
  always @(negedge clk) begin
    if (i2c_start) start_run++;
    else if (start_run != 0) begin
      last_start_len = start_run;
      start_run = 0;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic send(input logic [2:0] code, input logic [7:0] data, output res_t r);
    int n;
    r = '{default: 0};
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) fail_now("ready_wait");
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_code  = 3'd0;
    cmd_data  = 8'($urandom);
    r.lat    = 1;
    r.start1 = i2c_start;
    while (r.lat <= 100) begin
      if (we) begin
        r.we_n++;
        r.wd = wrt_data;
      end
      if (rdena) r.rd_n++;
      if (i2c_reset) r.rst_n++;
      if (rsp_valid) begin
        r.err  = rsp_err;
        r.data = rsp_data;
        break;
      end
      @(negedge clk);
      r.lat++;
    end
    if (r.lat > 100) fail_now("rsp_wait");
  endtask

  task automatic compare(input string tag, input res_t r, input res_t e);
    check({tag, ".err"}, r.err, e.err);
    check({tag, ".data"}, r.data, e.data);
    check({tag, ".lat"}, r.lat, e.lat);
    check({tag, ".we"}, r.we_n, e.we_n);
    if (e.we_n != 0) check({tag, ".wd"}, r.wd, e.wd);
    check({tag, ".rdena"}, r.rd_n, e.rd_n);
    check({tag, ".reset"}, r.rst_n, e.rst_n);
  endtask

  // Transaction-level expectation from command code and pending/sticky flags.
  task automatic model(input logic [2:0] code, input logic [7:0] data, input logic [7:0] rbk,
                       input logic [7:0] stat, output res_t e);
    e = '{default: 0};
    e.lat = 2;
    case (code)
      3'd1: if (m_pend) e.err = 1'b1;
            else begin e.lat = 3; e.we_n = 1; e.wd = data; end
      3'd2: if (m_pend) e.err = 1'b1;
            else m_pend = 1'b1;
      3'd3: begin e.lat = RST_LEN + 2; e.rst_n = RST_LEN; m_pend = 1'b0; end
      3'd4: if (m_pend) e.err = 1'b1;
            else begin e.lat = 3 + RD_LAT; e.rd_n = 1; e.data = rbk; end
      3'd5: begin e.err = m_sticky; e.data = stat; m_sticky = 1'b0; end
      default: e.err = 1'b1;
    endcase
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs[9];
  res_t r, e;
  int   n;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_data = '0;
    rbk_data = '0; status = '0; clr_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {rsp_valid, rsp_err, rsp_data, wrt_data, we, rdena, i2c_reset, i2c_start}, 0);
    check("reset.cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle.cmd_ready", cmd_ready, 1);

    // code, data, rbk, status -> {lat, we, wd, rd, rst, err, data, start1}
    vecs[0] = '{3'd1, 8'hA1, 8'h00, 8'h00, '{3, 1, 8'hA1, 0, 0, 1'b0, 8'h00, 1'b0}};
    vecs[1] = '{3'd1, 8'h80, 8'h00, 8'h00, '{3, 1, 8'h80, 0, 0, 1'b0, 8'h00, 1'b0}};
    vecs[2] = '{3'd4, 8'h00, 8'h5A, 8'h00, '{5, 0, 8'h00, 1, 0, 1'b0, 8'h5A, 1'b0}};
    vecs[3] = '{3'd7, 8'h11, 8'hFF, 8'hFF, '{2, 0, 8'h00, 0, 0, 1'b1, 8'h00, 1'b0}};
    vecs[4] = '{3'd0, 8'h22, 8'hFF, 8'hFF, '{2, 0, 8'h00, 0, 0, 1'b1, 8'h00, 1'b0}};
    vecs[5] = '{3'd6, 8'h33, 8'hFF, 8'hFF, '{2, 0, 8'h00, 0, 0, 1'b1, 8'h00, 1'b0}};
    vecs[6] = '{3'd5, 8'h00, 8'h00, 8'h3C, '{2, 0, 8'h00, 0, 0, 1'b0, 8'h3C, 1'b0}};
    vecs[7] = '{3'd3, 8'h00, 8'h00, 8'h00, '{13, 0, 8'h00, 0, 11, 1'b0, 8'h00, 1'b0}};
    vecs[8] = '{3'd4, 8'h00, 8'hC3, 8'h00, '{5, 0, 8'h00, 1, 0, 1'b0, 8'hC3, 1'b0}};
    for (int i = 0; i < 9; i++) begin
      rbk_data = vecs[i].rbk;
      status   = vecs[i].stat;
      send(vecs[i].code, vecs[i].data, r);
      compare($sformatf("vec%0d", i), r, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d.rsp_one_cycle", i), rsp_valid, 0);
    end

    // START held until CLR_START; a WRITE meanwhile is rejected without a WE.
    send(3'd2, 8'h00, r);
    check("start.lat", r.lat, 2);
    check("start.err", r.err, 0);
    check("start.level", r.start1, 1);
    send(3'd1, 8'h5F, r);
    check("wr_pend.err", r.err, 1);
    check("wr_pend.we", r.we_n, 0);
    check("wr_pend.lat", r.lat, 2);
    n = 0;
    while (n < 1000) begin
      @(negedge clk); #1;
      if (start_run >= 500) break;
      n++;
    end
    if (n >= 1000) fail_now("start_500_wait");
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    check("clr.start_low", i2c_start, 0);
    #1 check("clr.high_len", last_start_len, 500);
    status = 8'h96;
    send(3'd5, 8'h00, r);
    check("clr.status_err", r.err, 0);
    check("clr.status_data", r.data, 8'h96);

    // START never cleared: times out, sticky error reported once.
    send(3'd2, 8'h00, r);
    check("tmo.start_err", r.err, 0);
    n = 0;
    while (i2c_start && n < TMO + 1000) begin
      @(negedge clk);
      n++;
    end
    if (i2c_start) fail_now("tmo_wait");
    @(negedge clk); #1;
    check("tmo.high_len", last_start_len, TMO);
    send(3'd5, 8'h00, r);
    check("tmo.status1_err", r.err, 1);
    send(3'd5, 8'h00, r);
    check("tmo.status2_err", r.err, 0);

    // RESET while START pending.
    send(3'd2, 8'h00, r);
    check("rst_pend.start_err", r.err, 0);
    send(3'd3, 8'h00, r);
    check("rst_pend.start_next", r.start1, 0);
    check("rst_pend.reset_len", r.rst_n, RST_LEN);
    check("rst_pend.lat", r.lat, RST_LEN + 2);
    send(3'd1, 8'h42, r);
    check("rst_pend.write_ok", r.err, 0);
    check("rst_pend.write_we", r.we_n, 1);

    // RST in the middle of RHOLD aborts with no response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 3'd3;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_code = 3'd0;
    repeat (3) @(negedge clk);
    check("abort.reset_high", i2c_reset, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.outputs", {rsp_valid, rsp_err, rsp_data, wrt_data, we, rdena, i2c_reset, i2c_start}, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || i2c_reset) n++;
    end
    check("abort.no_rsp", n, 0);
    check("abort.ready", cmd_ready, 1);

    // CLR_START on the timeout cycle counts as a clear.
    send(3'd2, 8'h00, r);
    n = 0;
    while (n < TMO + 1000) begin
      @(negedge clk); #1;
      if (start_run >= TMO) break;
      n++;
    end
    if (n >= TMO + 1000) fail_now("coinc_wait");
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    check("coinc.start_low", i2c_start, 0);
    send(3'd5, 8'h00, r);
    check("coinc.status_err", r.err, 0);

    // Random command stream against the transaction model.
    pulse_rst();
    m_pend = 1'b0;
    m_sticky = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] c;
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        m_pend = 1'b0;
      end
      c = 3'($urandom_range(0, 7));
      d = 8'($urandom);
      rbk_data = 8'($urandom);
      status   = 8'($urandom);
      model(c, d, rbk_data, status, e);
      send(c, d, r);
      compare($sformatf("rnd%0d.c%0d", i, c), r, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
